// File: rtl/gen2_cmd_parser.sv
// gen2_cmd_parser: decodes Gen2 reader commands (opcode, fixed, EBV, length, payload, handle, CRC fields) from a demodulated bit stream.
// Latency: field state advances on the edge sampling a field's last bit; o_cmdok_dec / o_err_dec pulse in the following cycle.
// Backpressure: none, every i_valid_dem bit is consumed or ignored. Define GEN2_CMD_CRC_CHECK_EN to enable CRC-5/CRC-16 residue checking.
module gen2_cmd_parser #(
    parameter int HANDLE_W   = 16,
    parameter int EBV_BLOCKS = 3,
    parameter int LEN_W      = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_newcmd_dem,
    input  logic                    i_valid_dem,
    input  logic                    i_data_dem,
    input  logic                    i_preamble_dem,
    input  logic                    i_clear_cu,
    output logic [3:0]              o_cmd_id_dec,
    output logic [2:0]              o_field_id_dec,
    output logic                    o_field_shift_dec,
    output logic [7*EBV_BLOCKS-1:0] o_ebv_dec,
    output logic [HANDLE_W-1:0]     o_handle_dec,
    output logic [LEN_W-1:0]        o_len_dec,
    output logic                    o_cmdok_dec,
    output logic                    o_err_dec,
    output logic                    o_busy_dec
);
    localparam int EBV_W = 7 * EBV_BLOCKS;
    localparam int HW_B  = $clog2(HANDLE_W + 1);
    localparam int CW0   = (LEN_W > HW_B) ? LEN_W : HW_B;
    localparam int CNT_W = (CW0 > 5) ? CW0 : 5;
    localparam int BLK_W = $clog2(EBV_BLOCKS + 1);

    localparam logic [3:0] CMD_NONE  = 4'd0, CMD_QREP = 4'd1, CMD_ACK   = 4'd2,
                           CMD_QUERY = 4'd3, CMD_QADJ = 4'd4, CMD_NAK   = 4'd5,
                           CMD_REQRN = 4'd6, CMD_READ = 4'd7, CMD_WRITE = 4'd8,
                           CMD_AUTH  = 4'd9;

    typedef enum logic [3:0] {
        IDLE, OPCODE, FIXED, EBV, LENGTH, PAYLOAD, HANDLE, CRC, DONE, ERROR
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, field_len;
    logic [BLK_W-1:0]   blk;
    logic               ebv_ext, fixed_second, pre_seen;
    logic [6:0]         op_sr;
    logic [7:0]         op_nxt;
    logic [3:0]         cmd_id, cmd_hit;
    logic [EBV_W-1:0]   ebv_q;
    logic [HANDLE_W-1:0] handle_q;
    logic [LEN_W-1:0]   len_q, len_nxt;
    logic               in_field, consume, field_last, ebv_roll, crc_ok;
    logic [2:0]         field_id;

    assign op_nxt  = {op_sr, i_data_dem};
    assign len_nxt = {len_q[LEN_W-2:0], i_data_dem};

`ifdef GEN2_CMD_CRC_CHECK_EN
    logic [4:0]  crc5_q, crc5_nxt;
    logic [15:0] crc16_q, crc16_nxt;

    // Bit-serial CRC-5 (x^5+x^3+1) and CRC-16 (0x1021) next values for the incoming bit.
    always_comb begin
        crc5_nxt  = {crc5_q[3:0], 1'b0} ^ ((crc5_q[4] ^ i_data_dem) ? 5'b01001 : 5'b00000);
        crc16_nxt = {crc16_q[14:0], 1'b0} ^ ((crc16_q[15] ^ i_data_dem) ? 16'h1021 : 16'h0000);
    end

    // Both CRCs run over every consumed frame bit; preset at frame start or abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc5_q  <= 5'b01001;
            crc16_q <= 16'hFFFF;
        end else if (i_clear_cu || i_newcmd_dem) begin
            crc5_q  <= 5'b01001;
            crc16_q <= 16'hFFFF;
        end else if (consume) begin
            crc5_q  <= crc5_nxt;
            crc16_q <= crc16_nxt;
        end
    end

    // Residue evaluated including the final CRC bit; Query uses CRC-5.
    assign crc_ok = (cmd_id == CMD_QUERY) ? (crc5_nxt == 5'b00000) : (crc16_nxt == 16'h1D0F);
`else
    assign crc_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Field length per state, opcode matching and next-state selection.
    always_comb begin
        state_nxt = state;
        in_field  = 1'b0;
        field_id  = 3'd0;
        field_len = '0;
        cmd_hit   = CMD_NONE;
        ebv_roll  = 1'b0;
        case (state)
            OPCODE:  begin in_field = 1'b1; field_id = 3'd0; field_len = CNT_W'(8); end
            FIXED: begin
                in_field = 1'b1;
                field_id = 3'd1;
                case (cmd_id)
                    CMD_QREP:  field_len = CNT_W'(2);
                    CMD_QUERY: field_len = CNT_W'(13);
                    CMD_QADJ:  field_len = CNT_W'(5);
                    CMD_READ:  field_len = fixed_second ? CNT_W'(8) : CNT_W'(2);
                    CMD_WRITE: field_len = fixed_second ? CNT_W'(16) : CNT_W'(2);
                    CMD_AUTH:  field_len = CNT_W'(12);
                    default:   field_len = CNT_W'(1);
                endcase
            end
            EBV:     begin in_field = 1'b1; field_id = 3'd2; field_len = CNT_W'(8); end
            LENGTH:  begin in_field = 1'b1; field_id = 3'd3; field_len = CNT_W'(LEN_W); end
            PAYLOAD: begin in_field = 1'b1; field_id = 3'd4; field_len = CNT_W'(len_q); end
            HANDLE:  begin in_field = 1'b1; field_id = 3'd5; field_len = CNT_W'(HANDLE_W); end
            CRC: begin
                in_field  = 1'b1;
                field_id  = 3'd6;
                field_len = (cmd_id == CMD_QUERY) ? CNT_W'(5) : CNT_W'(16);
            end
            default: ;
        endcase

        consume    = i_valid_dem & in_field & ~i_newcmd_dem & ~i_clear_cu;
        field_last = consume & (cnt == field_len - CNT_W'(1));

        case (state)
            OPCODE: if (consume) begin
                // Prefix code: 2-bit codes start with 0, 4-bit with 10, 8-bit with 11.
                if (cnt == CNT_W'(1)) begin
                    if (op_nxt[1:0] == 2'b00)      cmd_hit = CMD_QREP;
                    else if (op_nxt[1:0] == 2'b01) cmd_hit = CMD_ACK;
                end else if (cnt == CNT_W'(3)) begin
                    if (op_nxt[3:0] == 4'b1000 && (pre_seen || i_preamble_dem)) cmd_hit = CMD_QUERY;
                    else if (op_nxt[3:0] == 4'b1001)                            cmd_hit = CMD_QADJ;
                end else if (cnt >= CNT_W'(7)) begin
                    case (op_nxt)
                        8'hC0:   cmd_hit = CMD_NAK;
                        8'hC1:   cmd_hit = CMD_REQRN;
                        8'hC2:   cmd_hit = CMD_READ;
                        8'hC3:   cmd_hit = CMD_WRITE;
                        8'hD5:   cmd_hit = CMD_AUTH;
                        default: cmd_hit = CMD_NONE;
                    endcase
                end
                case (cmd_hit)
                    CMD_NONE:           if (cnt >= CNT_W'(7)) state_nxt = ERROR;
                    CMD_ACK, CMD_REQRN: state_nxt = HANDLE;
                    CMD_NAK:            state_nxt = DONE;
                    default:            state_nxt = FIXED;
                endcase
            end
            FIXED: if (field_last) begin
                case (cmd_id)
                    CMD_QREP, CMD_QADJ:  state_nxt = DONE;
                    CMD_QUERY:           state_nxt = CRC;
                    CMD_READ, CMD_WRITE: state_nxt = fixed_second ? HANDLE : EBV;
                    CMD_AUTH:            state_nxt = LENGTH;
                    default:             state_nxt = ERROR;
                endcase
            end
            EBV: if (consume) begin
                // Extension bit set in the last permitted block means the value is too long.
                if (cnt == '0 && i_data_dem && blk == BLK_W'(EBV_BLOCKS - 1)) state_nxt = ERROR;
                else if (cnt == CNT_W'(7)) begin
                    if (!ebv_ext) state_nxt = FIXED;
                    else          ebv_roll  = 1'b1;
                end
            end
            LENGTH:  if (field_last) state_nxt = (len_nxt == '0) ? HANDLE : PAYLOAD;
            PAYLOAD: if (field_last) state_nxt = HANDLE;
            HANDLE:  if (field_last) state_nxt = (cmd_id == CMD_ACK) ? DONE : CRC;
            CRC:     if (field_last) state_nxt = crc_ok ? DONE : ERROR;
            DONE, ERROR: state_nxt = IDLE;
            default: ;
        endcase

        if (i_newcmd_dem) state_nxt = OPCODE;
        if (i_clear_cu)   state_nxt = IDLE;
    end

    // Field counters and captured field values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            blk          <= '0;
            ebv_ext      <= 1'b0;
            fixed_second <= 1'b0;
            pre_seen     <= 1'b0;
            op_sr        <= '0;
            cmd_id       <= CMD_NONE;
            ebv_q        <= '0;
            handle_q     <= '0;
            len_q        <= '0;
        end else if (i_clear_cu) begin
            cmd_id <= CMD_NONE;
            cnt    <= '0;
        end else if (i_newcmd_dem) begin
            cnt          <= '0;
            blk          <= '0;
            ebv_ext      <= 1'b0;
            fixed_second <= 1'b0;
            pre_seen     <= i_preamble_dem;
            op_sr        <= '0;
            cmd_id       <= CMD_NONE;
            ebv_q        <= '0;
            handle_q     <= '0;
            len_q        <= '0;
        end else begin
            if (state == OPCODE && i_preamble_dem) pre_seen <= 1'b1;
            if (consume) begin
                if (state_nxt != state || ebv_roll) cnt <= '0;
                else if (cnt != '1)                 cnt <= cnt + CNT_W'(1);
                case (state)
                    OPCODE: begin
                        op_sr <= op_nxt[6:0];
                        if (cmd_hit != CMD_NONE) cmd_id <= cmd_hit;
                    end
                    EBV: begin
                        if (cnt == '0) ebv_ext <= i_data_dem;
                        else           ebv_q   <= {ebv_q[EBV_W-2:0], i_data_dem};
                        if (ebv_roll)           blk          <= blk + BLK_W'(1);
                        if (state_nxt == FIXED) fixed_second <= 1'b1;
                    end
                    LENGTH: len_q    <= len_nxt;
                    HANDLE: handle_q <= {handle_q[HANDLE_W-2:0], i_data_dem};
                    default: ;
                endcase
            end
        end
    end

    assign o_cmd_id_dec      = cmd_id;
    assign o_field_id_dec    = field_id;
    assign o_field_shift_dec = consume;
    assign o_ebv_dec         = ebv_q;
    assign o_handle_dec      = handle_q;
    assign o_len_dec         = len_q;
    assign o_cmdok_dec       = (state == DONE) & ~i_clear_cu;
    assign o_err_dec         = (state == ERROR) & ~i_clear_cu;
    assign o_busy_dec        = (state != IDLE);
endmodule

// File: tb/tb_gen2_cmd_parser.sv
// tb_gen2_cmd_parser: directed frames for gen2_cmd_parser, expected results queued at stimulus time.
// Latency: results are popped when o_cmdok_dec / o_err_dec pulse; each frame is drained with a bounded wait.
// Backpressure: none; bits are driven one per cycle.
module tb_gen2_cmd_parser;
    localparam int HANDLE_W = 16, EBV_BLOCKS = 3, LEN_W = 12, EBV_W = 21;

`ifdef GEN2_CMD_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, i_newcmd_dem, i_valid_dem, i_data_dem, i_preamble_dem, i_clear_cu;
    logic [3:0]          o_cmd_id_dec;
    logic [2:0]          o_field_id_dec;
    logic                o_field_shift_dec, o_cmdok_dec, o_err_dec, o_busy_dec;
    logic [EBV_W-1:0]    o_ebv_dec;
    logic [HANDLE_W-1:0] o_handle_dec;
    logic [LEN_W-1:0]    o_len_dec;

    always #5 clk = ~clk;

    gen2_cmd_parser #(.HANDLE_W(HANDLE_W), .EBV_BLOCKS(EBV_BLOCKS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .i_newcmd_dem(i_newcmd_dem), .i_valid_dem(i_valid_dem),
        .i_data_dem(i_data_dem), .i_preamble_dem(i_preamble_dem), .i_clear_cu(i_clear_cu),
        .o_cmd_id_dec(o_cmd_id_dec), .o_field_id_dec(o_field_id_dec),
        .o_field_shift_dec(o_field_shift_dec), .o_ebv_dec(o_ebv_dec),
        .o_handle_dec(o_handle_dec), .o_len_dec(o_len_dec), .o_cmdok_dec(o_cmdok_dec),
        .o_err_dec(o_err_dec), .o_busy_dec(o_busy_dec)
    );

    typedef struct {
        logic                ok;
        logic [3:0]          cmd;
        logic                chk_dat;
        logic [EBV_W-1:0]    ebv;
        logic [HANDLE_W-1:0] handle;
        logic [LEN_W-1:0]    len;
    } exp_t;

    exp_t sb[$];
    bit   frm[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frm.push_back(v[i]);
    endtask

    function automatic logic [15:0] crc16_of();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (frm[i]) c = {c[14:0], 1'b0} ^ ((c[15] ^ frm[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    function automatic logic [4:0] crc5_of();
        logic [4:0] c;
        c = 5'b01001;
        foreach (frm[i]) c = {c[3:0], 1'b0} ^ ((c[4] ^ frm[i]) ? 5'b01001 : 5'b00000);
        return c;
    endfunction

    task automatic add_crc16(input bit flip);
        logic [15:0] c;
        c = ~crc16_of();
        if (flip) c[0] = ~c[0];
        push({16'h0, c}, 16);
    endtask

    task automatic add_crc5();
        logic [4:0] c;
        c = crc5_of();
        push({27'h0, c}, 5);
    endtask

    task automatic expect_res(input logic ok, input logic [3:0] cmd, input logic chk_dat,
                              input logic [EBV_W-1:0] ebv, input logic [HANDLE_W-1:0] h,
                              input logic [LEN_W-1:0] len);
        exp_t e;
        e.ok = ok; e.cmd = cmd; e.chk_dat = chk_dat; e.ebv = ebv; e.handle = h; e.len = len;
        sb.push_back(e);
    endtask

    task automatic start_frame(input logic pre);
        i_newcmd_dem = 1'b1; i_preamble_dem = pre;
        tick();
        i_newcmd_dem = 1'b0; i_preamble_dem = 1'b0;
    endtask

    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            i_valid_dem = 1'b1; i_data_dem = frm[i];
            tick();
        end
        i_valid_dem = 1'b0; i_data_dem = 1'b0;
    endtask

    task automatic send_frame(input logic pre);
        start_frame(pre);
        send_range(0, frm.size() - 1);
        frm.delete();
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin tick(); k++; end
        repeat (2) tick();
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cmd"},    32'(o_cmd_id_dec), 32'd0);
        chk({tag, "_field"},  32'(o_field_id_dec), 32'd0);
        chk({tag, "_shift"},  32'(o_field_shift_dec), 32'd0);
        chk({tag, "_ebv"},    32'(o_ebv_dec), 32'd0);
        chk({tag, "_handle"}, 32'(o_handle_dec), 32'd0);
        chk({tag, "_len"},    32'(o_len_dec), 32'd0);
        chk({tag, "_ok"},     32'(o_cmdok_dec), 32'd0);
        chk({tag, "_err"},    32'(o_err_dec), 32'd0);
        chk({tag, "_busy"},   32'(o_busy_dec), 32'd0);
    endtask

    // Scoreboard: every result pulse must match the oldest queued expectation.
    exp_t cur;
    always @(negedge clk) begin
        if (!rst && (o_cmdok_dec || o_err_dec)) begin
            chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                chk("cmdok", 32'(o_cmdok_dec), 32'(cur.ok));
                chk("err", 32'(o_err_dec), 32'(!cur.ok));
                chk("cmd_id", 32'(o_cmd_id_dec), 32'(cur.cmd));
                if (cur.chk_dat) begin
                    chk("ebv", 32'(o_ebv_dec), 32'(cur.ebv));
                    chk("handle", 32'(o_handle_dec), 32'(cur.handle));
                    chk("len", 32'(o_len_dec), 32'(cur.len));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_newcmd_dem = 1'b0; i_valid_dem = 1'b0; i_data_dem = 1'b0;
        i_preamble_dem = 1'b0; i_clear_cu = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        tick();

        // QueryRep 00 + session 10
        push(32'b00, 2); push(32'b10, 2);
        expect_res(1'b1, 4'd1, 1'b0, '0, '0, '0);
        send_frame(1'b0);
        drain("qrep_drain");

        // ACK 01 + RN
        push(32'b01, 2); push(32'h1234, 16);
        expect_res(1'b1, 4'd2, 1'b1, '0, 16'h1234, '0);
        send_frame(1'b0);
        drain("ack_drain");

        // Read C2, bank 11, EBV 81 05, count 04, handle A5A5, CRC-16
        push(32'hC2, 8); push(32'b11, 2); push(32'h81, 8); push(32'h05, 8);
        push(32'h04, 8); push(32'hA5A5, 16); add_crc16(1'b0);
        expect_res(1'b1, 4'd7, 1'b1, 21'd133, 16'hA5A5, 12'd0);
        start_frame(1'b0);
        send_range(0, 7);
        chk("read_field_fixed", 32'(o_field_id_dec), 32'd1);
        chk("read_busy", 32'(o_busy_dec), 32'd1);
        chk("read_cmd_early", 32'(o_cmd_id_dec), 32'd7);
        i_valid_dem = 1'b1; i_data_dem = frm[8];
        #1;
        chk("read_shift", 32'(o_field_shift_dec), 32'd1);
        send_range(8, frm.size() - 1);
        frm.delete();
        drain("read_drain");
        chk("read_handle_hold", 32'(o_handle_dec), 32'hA5A5);
        chk("read_idle", 32'(o_busy_dec), 32'd0);

        // Read with EBV overflow, trailing bits must be ignored
        push(32'hC2, 8); push(32'b00, 2); push(32'h81, 8); push(32'h81, 8); push(32'h81, 8);
        push(32'hFFFF, 16);
        expect_res(1'b0, 4'd7, 1'b0, '0, '0, '0);
        send_frame(1'b0);
        drain("ebv_ovf_drain");

        // Query prefix without preamble: falls through to unmatched 8-bit code
        push(32'b1000, 4); push(32'b0000, 4); push(32'h0, 13);
        expect_res(1'b0, 4'd0, 1'b0, '0, '0, '0);
        send_frame(1'b0);
        drain("qnopre_drain");

        // Query with preamble and CRC-5
        push(32'b1000, 4); push(32'h0A5B, 13); add_crc5();
        expect_res(1'b1, 4'd3, 1'b0, '0, '0, '0);
        send_frame(1'b1);
        drain("query_drain");

        // QueryAdjust and NAK
        push(32'b1001, 4); push(32'b10110, 5);
        expect_res(1'b1, 4'd4, 1'b0, '0, '0, '0);
        send_frame(1'b0);
        drain("qadj_drain");
        push(32'hC0, 8);
        expect_res(1'b1, 4'd5, 1'b0, '0, '0, '0);
        send_frame(1'b0);
        drain("nak_drain");

        // ReqRN and Write
        push(32'hC1, 8); push(32'h0F0F, 16); add_crc16(1'b0);
        expect_res(1'b1, 4'd6, 1'b1, '0, 16'h0F0F, '0);
        send_frame(1'b0);
        drain("reqrn_drain");
        push(32'hC3, 8); push(32'b01, 2); push(32'h05, 8); push(32'h1234, 16);
        push(32'hCAFE, 16); add_crc16(1'b0);
        expect_res(1'b1, 4'd8, 1'b1, 21'd5, 16'hCAFE, '0);
        send_frame(1'b0);
        drain("write_drain");

        // Authenticate, length 0x010, corrupted final CRC bit
        push(32'hD5, 8); push(32'h0, 12); push(32'h010, 12); push(32'hBEEF, 16);
        push(32'h1357, 16); add_crc16(1'b1);
        expect_res(!CRC_EN, 4'd9, 1'b1, '0, 16'h1357, 12'h010);
        send_frame(1'b0);
        drain("auth_bad_drain");

        // Authenticate with zero length skips payload
        push(32'hD5, 8); push(32'h0, 12); push(32'h000, 12); push(32'h2468, 16); add_crc16(1'b0);
        expect_res(1'b1, 4'd9, 1'b1, '0, 16'h2468, 12'h000);
        send_frame(1'b0);
        drain("auth_zero_drain");

        // Abort during ACK handle: no pulse, remaining bits ignored
        push(32'b01, 2); push(32'h1234, 16);
        start_frame(1'b0);
        send_range(0, 5);
        chk("clr_field_handle", 32'(o_field_id_dec), 32'd5);
        i_clear_cu = 1'b1; i_valid_dem = 1'b1; i_data_dem = frm[6];
        tick();
        i_clear_cu = 1'b0; i_valid_dem = 1'b0;
        chk("clr_busy", 32'(o_busy_dec), 32'd0);
        chk("clr_cmd", 32'(o_cmd_id_dec), 32'd0);
        send_range(7, frm.size() - 1);
        frm.delete();
        drain("clr_drain");

        // Clear beats a simultaneous new-command pulse
        i_newcmd_dem = 1'b1; i_clear_cu = 1'b1;
        tick();
        i_newcmd_dem = 1'b0; i_clear_cu = 1'b0;
        chk("clr_vs_new_busy", 32'(o_busy_dec), 32'd0);

        // Restart mid-frame: partial Read then a fresh QueryRep
        push(32'hC2, 8); push(32'b11, 2); push(32'h05, 8);
        start_frame(1'b0);
        send_range(0, 17);
        frm.delete();
        push(32'b00, 2); push(32'b01, 2);
        expect_res(1'b1, 4'd1, 1'b1, '0, '0, '0);
        send_frame(1'b0);
        drain("restart_drain");

        // Reset mid-frame
        push(32'hC3, 8); push(32'b01, 2); push(32'h05, 8); push(32'h12, 8);
        start_frame(1'b0);
        send_range(0, 19);
        frm.delete();
        chk("rst_mid_ebv_before", 32'(o_ebv_dec), 32'd5);
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        tick();
        rst = 1'b0;
        tick();
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gen2_cmd_parser.md
GEN2_CMD_PARSER -- requirements
Module: gen2_cmd_parser

Interface
REQ-001 SHALL have parameter HANDLE_W, default 16, handle/RN field width in bits.
REQ-002 SHALL have parameter EBV_BLOCKS, default 3, maximum accepted EBV blocks (7 value bits each).
REQ-003 SHALL have parameter LEN_W, default 12, width of Authenticate message-length field.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_newcmd_dem  in  1  one-cycle pulse: new frame starts.
REQ-007 i_valid_dem  in  1  one-cycle strobe: i_data_dem holds a decoded bit.
REQ-008 i_data_dem  in  1  decoded bit, MSB-first.
REQ-009 i_preamble_dem  in  1  frame began with preamble (Query only).
REQ-010 i_clear_cu  in  1  abort from control unit.
REQ-011 o_cmd_id_dec  out  4  0 none, 1 QueryRep, 2 ACK, 3 Query, 4 QueryAdjust, 5 NAK, 6 ReqRN, 7 Read, 8 Write, 9 Authenticate.
REQ-012 o_field_id_dec  out  3  field currently shifting: 0 opcode, 1 fixed, 2 EBV, 3 length, 4 payload, 5 handle, 6 CRC.
REQ-013 o_field_shift_dec  out  1  equals i_valid_dem while a field bit is consumed.
REQ-014 o_ebv_dec  out  7*EBV_BLOCKS  decoded EBV value, right-aligned.
REQ-015 o_handle_dec  out  HANDLE_W  received handle/RN.
REQ-016 o_len_dec  out  LEN_W  received Authenticate message length.
REQ-017 o_cmdok_dec  out  1  one-cycle pulse: frame complete and accepted.
REQ-018 o_err_dec  out  1  one-cycle pulse: frame rejected.
REQ-019 o_busy_dec  out  1  high in any state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, OPCODE, FIXED, EBV, LENGTH, PAYLOAD, HANDLE, CRC, DONE, ERROR.
REQ-021 IDLE->OPCODE on i_newcmd_dem; i_newcmd_dem in any state SHALL restart OPCODE with counters, CRC and o_cmd_id_dec cleared.
REQ-022 OPCODE SHALL match prefix codes at 2 bits (00,01), 4 bits (1000 needs i_preamble_dem, 1001), 8 bits (C0,C1,C2,C3,D5); unmatched 8-bit code -> ERROR.
REQ-023 Fixed-field lengths: QueryRep 2, Query 13, QueryAdjust 5, Read 2 then EBV then 8, Write 2 then EBV then 16, Authenticate 12 then LENGTH; ReqRN/ACK 0.
REQ-024 EBV: each 8-bit block = extension bit + 7 value bits; value shifts into o_ebv_dec; extension 0 ends EBV; extension 1 in block EBV_BLOCKS -> ERROR.
REQ-025 LENGTH SHALL capture LEN_W bits to o_len_dec; PAYLOAD SHALL consume exactly o_len_dec bits; o_len_dec==0 skips PAYLOAD.
REQ-026 HANDLE SHALL shift HANDLE_W bits; ACK goes to DONE after HANDLE (no CRC); QueryAdjust/QueryRep/NAK go to DONE after fixed field.
REQ-027 CRC state SHALL consume 5 bits for Query, 16 otherwise.
REQ-028 DONE SHALL pulse o_cmdok_dec next cycle, return to IDLE; ERROR SHALL pulse o_err_dec, return to IDLE; never both.
REQ-029 Field counters SHALL saturate; no wrap; bits arriving in DONE/ERROR/IDLE SHALL be ignored.
REQ-030 i_clear_cu SHALL force IDLE, clear o_cmd_id_dec, suppress pending pulses; i_newcmd_dem and i_clear_cu together: i_clear_cu wins.
REQ-031 o_handle_dec, o_ebv_dec, o_len_dec SHALL hold last values until next OPCODE entry.

Reset
REQ-032 rst SHALL force IDLE; all outputs 0; CRC registers to preset; effective immediately mid-frame.

Configuration
REQ-033 Macro GEN2_CMD_CRC_CHECK_EN defined: CRC-5 (x^5+x^3+1, preset 01001, residue 00000) and CRC-16 (0x1021, preset FFFF, residue 1D0F) run over all frame bits; residue mismatch at CRC end -> ERROR.
REQ-034 Macro undefined: CRC bits consumed but unchecked, every frame reaching CRC end -> DONE; no CRC registers synthesised.

Verification
REQ-035 QueryRep bits 00 then 10 -> o_cmd_id_dec=1, o_cmdok_dec one pulse, no o_err_dec.
REQ-036 Read C2, bank 11, EBV 0x81 0x05, count 0x04, handle 0xA5A5, valid CRC-16 -> o_ebv_dec=133, o_handle_dec=A5A5, o_cmdok_dec.
REQ-037 Read with EBV 0x81 0x81 0x81 (EBV_BLOCKS=3) -> o_err_dec, o_cmdok_dec never.
REQ-038 Query 1000 without i_preamble_dem -> continues to 8-bit match, unmatched -> o_err_dec.
REQ-039 Authenticate, length 0x010, 16 payload bits, flipped final CRC bit -> o_err_dec with GEN2_CMD_CRC_CHECK_EN, o_cmdok_dec without.
REQ-040 i_clear_cu during HANDLE of ACK -> IDLE next cycle, o_cmd_id_dec=0, no pulses; rst mid-frame -> all outputs 0.
